// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl_pkg
// Description : Shared constants for the AHB-Lite interrupt controller:
//               register word offsets (haddr[4:2]), HTRANS/HSIZE encodings
//               and a small helper that identifies active transfers.
// Revision    : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

    // Register word offsets, i.e. the value of haddr[4:2]
    localparam logic [2:0] c_off_status  = 3'd0;   // 0x00
    localparam logic [2:0] c_off_mask    = 3'd1;   // 0x04
    localparam logic [2:0] c_off_pending = 3'd2;   // 0x08
    localparam logic [2:0] c_off_mode    = 3'd3;   // 0x0C
    localparam logic [2:0] c_off_set     = 3'd4;   // 0x10

    // AHB-Lite HTRANS encodings
    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_busy   = 2'b01;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;

    // Only full-word writes are honoured
    localparam logic [1:0] c_hsize_word = 2'b10;

    // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY do not
    function automatic logic is_active_trans(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_ctrl_chan.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl_chan
// Description : One interrupt channel: input edge detection, edge/level mode
//               selection and the sticky status bit with set-over-clear
//               priority.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               i_int       - raw interrupt source
//               i_mode      - 1 = edge mode, 0 = level mode
//               i_set       - software set request (SET register write)
//               i_clr       - software clear request (W1C or read-to-clear)
//               o_status    - sticky status bit
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl_chan
    import int_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_int,
    input  logic i_mode,
    input  logic i_set,
    input  logic i_clr,
    output logic o_status
);

    logic r_prev_q;
    logic r_prev_d;
    logic r_status_q;
    logic r_status_d;
    logic w_hw_set;

    always_comb begin
        w_hw_set   = i_mode ? (i_int & ~r_prev_q) : i_int;
        // Any set source wins over a clear landing on the same edge, so an
        // event arriving while software clears the bit is never lost.
        r_status_d = w_hw_set | i_set | (r_status_q & ~i_clr);
        r_prev_d   = i_int;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_q   <= 1'b0;
            r_status_q <= 1'b0;
        end else begin
            r_prev_q   <= r_prev_d;
            r_status_q <= r_status_d;
        end
    end

    assign o_status = r_status_q;

endmodule
`default_nettype wire

// File: rtl/int_ctrl_ahb.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl_ahb
// Description : Interrupt controller with an AHB-Lite slave register port.
//               Registers: STATUS (W1C), MASK, PENDING (optional R2C), MODE,
//               SET (W1S). Zero wait states, never errors.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               ahb_*                - AHB-Lite slave interface
//               int_in[NCH]          - interrupt sources (pulse or level)
//               int_vec_out[NCH]     - STATUS & MASK
//               int_level_out        - OR of int_vec_out
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl_ahb
    import int_ctrl_pkg::*;
#(
    parameter int             NCH      = 8,
    parameter int             R2C      = 1,
    parameter logic [NCH-1:0] MASK_RST = {NCH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ahb_hsel,
    input  logic [31:0]      ahb_haddr,
    input  logic [1:0]       ahb_hsize,
    input  logic [1:0]       ahb_htrans,
    input  logic [31:0]      ahb_hwdata,
    input  logic             ahb_hwrite,
    output logic [31:0]      ahb_hrdata,
    output logic             ahb_hresp,
    output logic             ahb_hready,
    input  logic [NCH-1:0]   int_in,
    output logic [NCH-1:0]   int_vec_out,
    output logic             int_level_out
);

    // Data-phase record captured from the address phase
    logic           r_dp_valid_q, r_dp_valid_d;
    logic [2:0]     r_dp_off_q,   r_dp_off_d;
    logic           r_dp_write_q, r_dp_write_d;
    logic [1:0]     r_dp_size_q,  r_dp_size_d;

    logic [NCH-1:0] r_mask_q, r_mask_d;
    logic [NCH-1:0] r_mode_q, r_mode_d;

    logic [NCH-1:0] w_status;
    logic [NCH-1:0] w_pending;
    logic [NCH-1:0] w_w1c;
    logic [NCH-1:0] w_set;
    logic [NCH-1:0] w_r2c;
    logic [NCH-1:0] w_clr;
    logic [31:0]    w_rdata;
    logic           w_wr_ok;
    logic           w_rd_ok;
    logic           w_unused;

    // Address bits outside [4:2], htrans[0] and the upper write-data bits
    // carry no meaning for this register file.
    assign w_unused = ^{ahb_haddr[31:5], ahb_haddr[1:0], ahb_htrans[0], ahb_hwdata};

    assign w_pending = w_status & r_mask_q;

    always_comb begin
        r_dp_valid_d = ahb_hsel & is_active_trans(ahb_htrans);
        r_dp_off_d   = ahb_haddr[4:2];
        r_dp_write_d = ahb_hwrite;
        r_dp_size_d  = ahb_hsize;

        w_wr_ok  = r_dp_valid_q & r_dp_write_q & (r_dp_size_q == c_hsize_word);
        w_rd_ok  = r_dp_valid_q & ~r_dp_write_q;

        r_mask_d = r_mask_q;
        r_mode_d = r_mode_q;
        w_w1c    = '0;
        w_set    = '0;
        w_r2c    = '0;
        w_rdata  = '0;

        if (w_wr_ok) begin
            case (r_dp_off_q)
                c_off_status: w_w1c    = ahb_hwdata[NCH-1:0];
                c_off_mask:   r_mask_d = ahb_hwdata[NCH-1:0];
                c_off_mode:   r_mode_d = ahb_hwdata[NCH-1:0];
                c_off_set:    w_set    = ahb_hwdata[NCH-1:0];
                default: ;
            endcase
        end

        if (w_rd_ok) begin
            case (r_dp_off_q)
                c_off_status:  w_rdata[NCH-1:0] = w_status;
                c_off_mask:    w_rdata[NCH-1:0] = r_mask_q;
                c_off_pending: w_rdata[NCH-1:0] = w_pending;
                c_off_mode:    w_rdata[NCH-1:0] = r_mode_q;
                default: ;
            endcase
        end

        // Read-to-clear removes exactly the bits returned on the bus
        if ((R2C != 0) && w_rd_ok && (r_dp_off_q == c_off_pending)) begin
            w_r2c = w_pending;
        end

        w_clr = w_w1c | w_r2c;
    end

    // Reset wins over everything, so a data phase coinciding with reset is
    // discarded without applying its write or read-to-clear side effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dp_valid_q <= 1'b0;
            r_dp_off_q   <= '0;
            r_dp_write_q <= 1'b0;
            r_dp_size_q  <= '0;
            r_mask_q     <= MASK_RST;
            r_mode_q     <= '1;
        end else begin
            r_dp_valid_q <= r_dp_valid_d;
            r_dp_off_q   <= r_dp_off_d;
            r_dp_write_q <= r_dp_write_d;
            r_dp_size_q  <= r_dp_size_d;
            r_mask_q     <= r_mask_d;
            r_mode_q     <= r_mode_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            int_ctrl_chan u_chan (
                .clk      (clk),
                .reset    (reset),
                .i_int    (int_in[gi]),
                .i_mode   (r_mode_q[gi]),
                .i_set    (w_set[gi]),
                .i_clr    (w_clr[gi]),
                .o_status (w_status[gi])
            );
        end
    endgenerate

    assign ahb_hrdata    = w_rdata;
    assign ahb_hresp     = 1'b0;
    assign ahb_hready    = 1'b1;
    assign int_vec_out   = w_pending;
    assign int_level_out = |w_pending;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl_ahb.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_ctrl_ahb
// Description : Self-checking bench for int_ctrl_ahb. Directed scenarios for
//               edge/level capture, read-to-clear, collisions, back-to-back
//               transfers and mid-transfer reset, followed by randomized bus
//               and interrupt traffic checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl_ahb;

    localparam int             NCH      = 8;
    localparam int             R2C      = 1;
    localparam logic [NCH-1:0] MASK_RST = 8'h00;

    localparam logic [31:0] A_STATUS  = 32'h00;
    localparam logic [31:0] A_MASK    = 32'h04;
    localparam logic [31:0] A_PENDING = 32'h08;
    localparam logic [31:0] A_MODE    = 32'h0C;
    localparam logic [31:0] A_SET     = 32'h10;

    logic             clk = 1'b0;
    logic             reset;
    logic             ahb_hsel;
    logic [31:0]      ahb_haddr;
    logic [1:0]       ahb_hsize;
    logic [1:0]       ahb_htrans;
    logic [31:0]      ahb_hwdata;
    logic             ahb_hwrite;
    logic [31:0]      ahb_hrdata;
    logic             ahb_hresp;
    logic             ahb_hready;
    logic [NCH-1:0]   int_in;
    logic [NCH-1:0]   int_vec_out;
    logic             int_level_out;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [NCH-1:0] m_status = '0;
    logic [NCH-1:0] m_mask   = '0;
    logic [NCH-1:0] m_mode   = '1;
    logic [NCH-1:0] m_prev   = '0;
    logic           m_known  = 1'b0;
    logic           m_dp_valid = 1'b0;
    logic           m_dp_write = 1'b0;
    logic [2:0]     m_dp_off   = '0;
    logic [1:0]     m_dp_size  = '0;
    logic [31:0]    m_dp_wdata = '0;

    logic [NCH-1:0] irq_v = '0;
    logic [31:0]    last_rd = '0;

    int_ctrl_ahb #(
        .NCH      (NCH),
        .R2C      (R2C),
        .MASK_RST (MASK_RST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ahb_hsel      (ahb_hsel),
        .ahb_haddr     (ahb_haddr),
        .ahb_hsize     (ahb_hsize),
        .ahb_htrans    (ahb_htrans),
        .ahb_hwdata    (ahb_hwdata),
        .ahb_hwrite    (ahb_hwrite),
        .ahb_hrdata    (ahb_hrdata),
        .ahb_hresp     (ahb_hresp),
        .ahb_hready    (ahb_hready),
        .int_in        (int_in),
        .int_vec_out   (int_vec_out),
        .int_level_out (int_level_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Register view as software sees it
    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0:    return 32'(m_status);
            3'd1:    return 32'(m_mask);
            3'd2:    return 32'(m_status & m_mask);
            3'd3:    return 32'(m_mode);
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle. Called at posedge+1: drives the address phase of a
    // new transfer plus write data of the transfer now in its data phase,
    // checks outputs mid-cycle, then advances the model across the edge.
    task automatic tick(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                        input logic wr, input logic [1:0] sz, input logic [31:0] wdata,
                        input logic rst_v);
        logic [31:0]    exp_rd;
        logic [NCH-1:0] ns;
        logic           full_wr;
        logic           is_rd;
        reset      = rst_v;
        ahb_hsel   = sel;
        ahb_htrans = trans;
        ahb_haddr  = addr;
        ahb_hwrite = wr;
        ahb_hsize  = sz;
        ahb_hwdata = m_dp_wdata;
        int_in     = irq_v;
        #4;
        exp_rd  = model_read(m_dp_off);
        full_wr = m_dp_valid && m_dp_write && (m_dp_size == 2'b10);
        is_rd   = m_dp_valid && !m_dp_write;
        if (m_known) begin
            if (is_rd) begin
                last_rd = ahb_hrdata;
                check("hrdata", ahb_hrdata, exp_rd);
            end
            check("int_vec", 32'(int_vec_out), 32'(m_status & m_mask));
            check("int_level", 32'(int_level_out), 32'(|(m_status & m_mask)));
        end
        if (rst_v) begin
            m_status   = '0;
            m_mask     = MASK_RST;
            m_mode     = '1;
            m_prev     = '0;
            m_known    = 1'b1;
            m_dp_valid = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                logic rise, hw, sw_set, sw_clr;
                rise   = irq_v[i] && !m_prev[i];
                hw     = m_mode[i] ? rise : irq_v[i];
                sw_set = full_wr && (m_dp_off == 3'd4) && m_dp_wdata[i];
                sw_clr = (full_wr && (m_dp_off == 3'd0) && m_dp_wdata[i]) ||
                         ((R2C != 0) && is_rd && (m_dp_off == 3'd2) && exp_rd[i]);
                if (hw || sw_set)  ns[i] = 1'b1;
                else if (sw_clr)   ns[i] = 1'b0;
                else               ns[i] = m_status[i];
            end
            if (full_wr && (m_dp_off == 3'd1)) m_mask = m_dp_wdata[NCH-1:0];
            if (full_wr && (m_dp_off == 3'd3)) m_mode = m_dp_wdata[NCH-1:0];
            m_status   = ns;
            m_prev     = irq_v;
            m_dp_valid = sel && trans[1];
        end
        m_dp_write = wr;
        m_dp_off   = addr[4:2];
        m_dp_size  = sz;
        m_dp_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 2'b00, 32'h0, 1'b0, 2'b10, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        tick(1'b1, 2'b10, addr, 1'b1, 2'b10, data, 1'b0);
    endtask

    task automatic rd(input logic [31:0] addr);
        tick(1'b1, 2'b10, addr, 1'b0, 2'b10, 32'h0, 1'b0);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        rd(addr);
        idle();
        check(tag, last_rd, exp);
    endtask

    initial begin
        logic [31:0] rnd;
        logic        r_sel, r_wr, r_rst;
        logic [1:0]  r_trans, r_sz;
        logic [31:0] r_addr, r_data;

        reset = 1'b1; ahb_hsel = 1'b0; ahb_haddr = '0; ahb_hsize = 2'b10;
        ahb_htrans = 2'b00; ahb_hwdata = '0; ahb_hwrite = 1'b0; int_in = '0;
        @(posedge clk);
        #1;
        tick(1'b0, 2'b00, 32'h0, 1'b0, 2'b10, 32'h0, 1'b1);
        tick(1'b0, 2'b00, 32'h0, 1'b0, 2'b10, 32'h0, 1'b1);
        idle();

        // Reset state
        check("rst_hrdata", ahb_hrdata, 32'h0);
        check("rst_hresp", 32'(ahb_hresp), 32'h0);
        check("rst_hready", 32'(ahb_hready), 32'h1);
        check("rst_vec", 32'(int_vec_out), 32'h0);
        rd_check("rst_status", A_STATUS, 32'h0);
        rd_check("rst_mask", A_MASK, 32'(MASK_RST));
        rd_check("rst_mode", A_MODE, 32'hFF);

        // Edge capture of a one-cycle pulse, then a held level after W1C
        wr(A_MASK, 32'h01);
        irq_v = 8'h01; idle();
        irq_v = 8'h00; idle();
        check("pulse_level", 32'(int_level_out), 32'h1);
        rd_check("pulse_status", A_STATUS, 32'h01);
        irq_v = 8'h01; idle(); idle();
        wr(A_STATUS, 32'h01); idle(); idle();
        rd_check("held_edge_no_reset", A_STATUS, 32'h0);
        irq_v = 8'h00; idle();

        // Level mode re-sets immediately after W1C
        wr(A_MODE, 32'h00);
        irq_v = 8'h08; idle();
        wr(A_STATUS, 32'h08); idle();
        rd_check("level_reset", A_STATUS, 32'h08);
        irq_v = 8'h00; idle();
        wr(A_STATUS, 32'hFF); wr(A_MODE, 32'hFF); idle();

        // Read-to-clear of PENDING
        wr(A_SET, 32'h0F); wr(A_MASK, 32'h05); idle();
        rd_check("r2c_return", A_PENDING, 32'h05);
        check("r2c_level", 32'(int_level_out), 32'h0);
        rd_check("r2c_status", A_STATUS, 32'h0A);
        rd_check("set_read_zero", A_SET, 32'h0);

        // Hardware set on the same edge as W1C of the same bit
        wr(A_STATUS, 32'hFF); idle();
        wr(A_STATUS, 32'h04);
        irq_v = 8'h04; idle();
        irq_v = 8'h00;
        rd_check("collision", A_STATUS, 32'h04);

        // Back-to-back transfers with no idle cycles
        wr(A_STATUS, 32'hFF); idle();
        wr(A_MASK, 32'hFF); rd(A_MASK); wr(A_SET, 32'h80);
        check("b2b_mask", last_rd, 32'hFF);
        idle();
        rd_check("b2b_status", A_STATUS, 32'h80);

        // Non-word write ignored, unmapped offset reads zero
        tick(1'b1, 2'b10, A_MASK, 1'b1, 2'b01, 32'h00, 1'b0); idle();
        rd_check("hsize_ignored", A_MASK, 32'hFF);
        rd_check("unmapped", 32'h18, 32'h0);

        // Reset coinciding with a W1C data phase
        wr(A_SET, 32'h33); idle();
        wr(A_STATUS, 32'h01);
        tick(1'b0, 2'b00, 32'h0, 1'b0, 2'b10, 32'h0, 1'b1);
        idle();
        rd_check("midrst_status", A_STATUS, 32'h0);
        rd_check("midrst_mask", A_MASK, 32'(MASK_RST));

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rnd = $urandom;
            if (rnd[3:0] == 4'd0) irq_v = rnd[31:24];
            r_sel   = (rnd[6:4] != 3'd0);
            r_trans = rnd[8:7];
            r_wr    = rnd[9];
            r_sz    = (rnd[11:10] == 2'd0) ? rnd[13:12] : 2'b10;
            r_rst   = (rnd[20:14] == 7'd0);
            rnd     = $urandom;
            r_addr  = rnd;
            r_data  = $urandom;
            tick(r_sel, r_trans, r_addr, r_wr, r_sz, r_data, r_rst);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/int_ctrl_ahb.md
INT_CTRL_AHB -- requirements
Module: int_ctrl_ahb

Interface
REQ-001 SHALL have parameter NCH, default 8, number of interrupt channels, legal range 1..32.
REQ-002 SHALL have parameter R2C, default 1; 1 = a read of PENDING clears the returned bits, 0 = PENDING is pure read-only.
REQ-003 SHALL have parameter MASK_RST, default {NCH{1'b0}}, reset value of MASK.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  in  1  synchronous reset, active-high.
REQ-006 SHALL have ports ahb_hsel in 1, ahb_haddr in 32, ahb_hsize in 2, ahb_htrans in 2, ahb_hwdata in 32 and ahb_hwrite in 1, forming the AHB-Lite slave inputs.
REQ-007 SHALL have ports ahb_hrdata out 32, ahb_hresp out 1 and ahb_hready out 1, forming the AHB-Lite slave outputs.
REQ-008 SHALL have port int_in  in  NCH  per-channel interrupt sources, pulse or level.
REQ-009 SHALL have port int_vec_out  out  NCH  per-channel masked interrupt (STATUS & MASK).
REQ-010 SHALL have port int_level_out  out  1  OR of int_vec_out.

Function
REQ-011 SHALL drive ahb_hresp = 0 and ahb_hready = 1 permanently (zero wait states).
REQ-012 SHALL capture an address phase when ahb_hsel & ahb_htrans[1] is true, registering ahb_haddr[4:2], ahb_hwrite and ahb_hsize; IDLE/BUSY SHALL be ignored.
REQ-013 SHALL in the data phase (cycle after capture) drive ahb_hrdata combinationally from the registered offset; writes SHALL use ahb_hwdata of the data phase and take effect at its closing edge.
REQ-014 SHALL ignore writes with hsize != 2'b10; reads of any size return the full word.
REQ-015 SHALL map 0x00 STATUS: read = sticky status, write-1-to-clear.
REQ-016 SHALL map 0x04 MASK: read/write enable.
REQ-017 SHALL map 0x08 PENDING: read = STATUS & MASK, writes ignored.
REQ-018 SHALL map 0x0C MODE: read/write, bit = 1 edge mode, 0 level mode.
REQ-019 SHALL map 0x10 SET: write-1-to-set STATUS, read returns 0.
REQ-020 SHALL return 0 on unmapped offsets 0x14..0x1C and ignore writes to them; bits [31:NCH] SHALL read 0 and ignore writes.
REQ-021 SHALL set STATUS[i], in edge mode, at the edge where int_in[i] = 1 and its registered previous value = 0; a level held high sets the bit only once.
REQ-022 SHALL set STATUS[i], in level mode, at every edge where int_in[i] = 1, so the bit re-sets immediately after a clear while the source remains high.
REQ-023 SHALL, with R2C = 1, clear exactly the PENDING bits returned in ahb_hrdata at the closing edge of the read data phase; masked bits SHALL be untouched.
REQ-024 SHALL give set precedence when a hardware set, SET write, W1C or R2C clear hit the same bit in the same cycle: the bit ends at 1, so no event is lost.
REQ-025 SHALL produce int_vec_out and int_level_out combinationally from STATUS and MASK registers, asserting in the cycle after the setting edge.
REQ-026 SHALL keep STATUS unaffected by MASK changes; unmasking an already-set bit asserts the output immediately.
REQ-027 SHALL accept back-to-back transfers (address phase N+1 overlapping data phase N) without bubbles.

Reset
REQ-028 SHALL, on reset, set STATUS = 0, MASK = MASK_RST, MODE = all-ones (edge), the previous-input register = 0 and the data-phase valid flag = 0; int_vec_out = 0, int_level_out = 0, ahb_hrdata = 0.
REQ-029 SHALL abort a data phase coinciding with reset: no write and no R2C clear is applied.
REQ-030 SHALL not latch an int_in edge during reset; after release, an input already high is seen as an edge only if it was 0 in the first sampled cycle.

Structure
REQ-031 SHALL place the register offset constants (STATUS, MASK, PENDING, MODE, SET) and the HTRANS encodings in shared package int_ctrl_pkg.
REQ-032 SHALL implement per-channel capture (edge detect, mode select, set/clear priority) in sub-module int_ctrl_chan, instantiated NCH times via generate.

Verification
REQ-033 SHALL verify edge capture: NCH=8, MASK=0x01, 1-cycle pulse on int_in[0] -> STATUS=0x01, int_level_out=1 next cycle; a held level yields no re-set after W1C 0x01.
REQ-034 SHALL verify level mode: MODE=0x00, int_in[3] held high, W1C 0x08 -> STATUS[3] reads 1 again one cycle later.
REQ-035 SHALL verify R2C: STATUS=0x0F, MASK=0x05, read PENDING -> returns 0x05; STATUS then 0x0A and int_level_out=0.
REQ-036 SHALL verify collision: int_in[2] edge on the same edge as W1C 0x04 -> STATUS[2]=1.
REQ-037 SHALL verify back-to-back: write MASK=0xFF, then read MASK, then write SET=0x80 with no idle -> read returns 0xFF, STATUS=0x80.
REQ-038 SHALL verify mid-op reset: reset asserted during a W1C data phase -> STATUS=0, MASK=MASK_RST, no residual clear after release.
